// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined
//   Decode stage of the 5-stage pipeline. It contains the following parts:
//   - a 32 x DATA_W register file with write-through bypass;
//   - a RAW/load-use hazard detector;
//   - the ID/EX pipeline register, with bubble and flush handling;
//   - a saturating counter of freeze cycles.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_valid, instruction, pc_in  IF/ID contents
//   src2_is_reg                   instruction reads rt
//   exe/mem/wb_ctrl_in            controller bundles for this instruction
//   wb_en, wb_dest, wb_data       register-file write port
//   exe_wb_en, exe_dest,
//   exe_mem_read                  producer currently in EXE
//   mem_wb_en, mem_dest           producer currently in MEM
//   flush                         taken branch in EXE, squash ID
//   opcode, funct, freeze         combinational decode / stall outputs
//   id_ex_*                       registered ID/EX fields
//   stall_count                   saturating count of freeze cycles
module id_stage_pipelined #(
    parameter int DATA_W     = 32,
    parameter int EXE_CTRL_W = 6,
    parameter int MEM_CTRL_W = 2,
    parameter int WB_CTRL_W  = 2,
    parameter int FORWARD_EN = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           instruction,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  src2_is_reg,
    input  logic [EXE_CTRL_W-1:0] exe_ctrl_in,
    input  logic [MEM_CTRL_W-1:0] mem_ctrl_in,
    input  logic [WB_CTRL_W-1:0]  wb_ctrl_in,
    input  logic                  wb_en,
    input  logic [4:0]            wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  exe_wb_en,
    input  logic [4:0]            exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [4:0]            mem_dest,
    input  logic                  flush,
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    output logic                  freeze,
    output logic                  id_ex_valid,
    output logic [DATA_W-1:0]     id_ex_pc,
    output logic [DATA_W-1:0]     id_ex_val1,
    output logic [DATA_W-1:0]     id_ex_val2,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [4:0]            id_ex_rs,
    output logic [4:0]            id_ex_rt,
    output logic [4:0]            id_ex_rd,
    output logic [EXE_CTRL_W-1:0] id_ex_exe_ctrl,
    output logic [MEM_CTRL_W-1:0] id_ex_mem_ctrl,
    output logic [WB_CTRL_W-1:0]  id_ex_wb_ctrl,
    output logic [CNT_W-1:0]      stall_count
);

    logic [DATA_W-1:0] regs [32];
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] val1, val2, imm_ext;
    logic              wr_ok;
    logic              exe_hit, mem_hit, hazard, bubble;

    assign opcode  = instruction[31:26];
    assign funct   = instruction[5:0];
    assign rs      = instruction[25:21];
    assign rt      = instruction[20:16];
    assign rd      = instruction[15:11];
    assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    assign wr_ok   = wb_en && (wb_dest != 5'd0);

    // Register file; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Reads: r0 is hard zero, then write-through bypass, then storage.
    always_comb begin
        val1 = regs[rs];
        val2 = regs[rt];
        if (wr_ok && wb_dest == rs) val1 = wb_data;
        if (wr_ok && wb_dest == rt) val2 = wb_data;
        if (rs == 5'd0) val1 = '0;
        if (rt == 5'd0) val2 = '0;
    end

    // Hazard detection; rt only participates when the instruction reads it.
    always_comb begin
        exe_hit = exe_wb_en && (
                  (exe_dest == rs && rs != 5'd0) ||
                  (src2_is_reg && exe_dest == rt && rt != 5'd0));
        mem_hit = mem_wb_en && (
                  (mem_dest == rs && rs != 5'd0) ||
                  (src2_is_reg && mem_dest == rt && rt != 5'd0));
        if (FORWARD_EN != 0) hazard = if_valid && exe_mem_read && exe_hit;
        else                 hazard = if_valid && (exe_hit || mem_hit);
    end

    assign freeze = hazard && !flush;
    assign bubble = flush || hazard;

    // ID/EX register: reset, then bubble, then normal load.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            id_ex_valid    <= 1'b0;
            id_ex_pc       <= '0;
            id_ex_val1     <= '0;
            id_ex_val2     <= '0;
            id_ex_imm      <= '0;
            id_ex_rs       <= '0;
            id_ex_rt       <= '0;
            id_ex_rd       <= '0;
            id_ex_exe_ctrl <= '0;
            id_ex_mem_ctrl <= '0;
            id_ex_wb_ctrl  <= '0;
        end else begin
            id_ex_valid    <= if_valid;
            id_ex_pc       <= pc_in;
            id_ex_val1     <= val1;
            id_ex_val2     <= val2;
            id_ex_imm      <= imm_ext;
            id_ex_rs       <= rs;
            id_ex_rt       <= rt;
            id_ex_rd       <= rd;
            id_ex_exe_ctrl <= if_valid ? exe_ctrl_in : '0;
            id_ex_mem_ctrl <= if_valid ? mem_ctrl_in : '0;
            id_ex_wb_ctrl  <= if_valid ? wb_ctrl_in  : '0;
        end
    end

    // Freeze-cycle counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (freeze && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        src2_is_reg;
    logic [5:0]  exe_ctrl_in;
    logic [1:0]  mem_ctrl_in;
    logic [1:0]  wb_ctrl_in;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        exe_wb_en;
    logic [4:0]  exe_dest;
    logic        exe_mem_read;
    logic        mem_wb_en;
    logic [4:0]  mem_dest;
    logic        flush;

    // dut a: no forwarding, 4-bit counter; dut b: forwarding, 16-bit counter
    logic [5:0]  opcode_a, funct_a, opcode_b, funct_b;
    logic        freeze_a, freeze_b, valid_a, valid_b;
    logic [31:0] pc_a, val1_a, val2_a, imm_a, pc_b, val1_b, val2_b, imm_b;
    logic [4:0]  rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
    logic [5:0]  exc_a, exc_b;
    logic [1:0]  mec_a, mec_b, wbc_a, wbc_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_stage_pipelined #(.FORWARD_EN(0), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .pc_in(pc_in), .src2_is_reg(src2_is_reg), .exe_ctrl_in(exe_ctrl_in),
        .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .flush(flush), .opcode(opcode_a), .funct(funct_a),
        .freeze(freeze_a), .id_ex_valid(valid_a), .id_ex_pc(pc_a),
        .id_ex_val1(val1_a), .id_ex_val2(val2_a), .id_ex_imm(imm_a),
        .id_ex_rs(rs_a), .id_ex_rt(rt_a), .id_ex_rd(rd_a),
        .id_ex_exe_ctrl(exc_a), .id_ex_mem_ctrl(mec_a), .id_ex_wb_ctrl(wbc_a),
        .stall_count(cnt_a)
    );

    id_stage_pipelined #(.FORWARD_EN(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
        .pc_in(pc_in), .src2_is_reg(src2_is_reg), .exe_ctrl_in(exe_ctrl_in),
        .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .flush(flush), .opcode(opcode_b), .funct(funct_b),
        .freeze(freeze_b), .id_ex_valid(valid_b), .id_ex_pc(pc_b),
        .id_ex_val1(val1_b), .id_ex_val2(val2_b), .id_ex_imm(imm_b),
        .id_ex_rs(rs_b), .id_ex_rt(rt_b), .id_ex_rd(rd_b),
        .id_ex_exe_ctrl(exc_b), .id_ex_mem_ctrl(mec_b), .id_ex_wb_ctrl(wbc_b),
        .stall_count(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [4:0] d,
                                       input logic [5:0] fn);
        return {op, s, t, d, 5'd0, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; instruction = '0; pc_in = '0; src2_is_reg = 1'b0;
        exe_ctrl_in = '0; mem_ctrl_in = '0; wb_ctrl_in = '0;
        wb_en = 1'b0; wb_dest = '0; wb_data = '0;
        exe_wb_en = 1'b0; exe_dest = '0; exe_mem_read = 1'b0;
        mem_wb_en = 1'b0; mem_dest = '0; flush = 1'b0;
    endtask

    initial begin
        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_valid = 1'($urandom); instruction = $urandom; pc_in = $urandom;
            src2_is_reg = 1'($urandom); exe_ctrl_in = 6'($urandom);
            mem_ctrl_in = 2'($urandom); wb_ctrl_in = 2'($urandom);
            wb_en = 1'($urandom); wb_dest = 5'($urandom); wb_data = $urandom;
            exe_wb_en = 1'($urandom); exe_dest = 5'($urandom);
            exe_mem_read = 1'($urandom); mem_wb_en = 1'($urandom);
            mem_dest = 5'($urandom); flush = 1'($urandom);
            tick();
        end
        check("rst_valid", {valid_a, valid_b}, 2'b00);
        check("rst_fields", {pc_a, val1_a}, 64'd0);
        check("rst_fields2", {val2_a, imm_a}, 64'd0);
        check("rst_regs_ctrl", {rs_a, rt_a, rd_a, exc_a, mec_a, wbc_a}, 64'd0);
        check("rst_count", {cnt_a, cnt_b}, 64'd0);
        idle();
        rst = 1'b0;
        #1;
        check("idle_freeze", {freeze_a, freeze_b}, 2'b00);

        // read r5 after reset
        if_valid = 1'b1; instruction = mk(6'h00, 5'd5, 5'd0, 5'd0, 6'h20);
        tick();
        check("r5_after_rst", val1_a, 32'd0);
        check("r5_valid", valid_a, 1'b1);

        // write-through bypass into the same-cycle read
        wb_en = 1'b1; wb_dest = 5'd5; wb_data = 32'hDEADBEEF;
        instruction = mk(6'h23, 5'd5, 5'd0, 5'b10000, 6'h21);
        pc_in = 32'h100; exe_ctrl_in = 6'h2A; mem_ctrl_in = 2'd2; wb_ctrl_in = 2'd1;
        #1;
        check("byp_freeze", freeze_a, 1'b0);
        check("opcode", opcode_a, 6'h23);
        check("funct", funct_a, 6'h21);
        tick();
        check("byp_val1", val1_a, 32'hDEADBEEF);
        check("byp_pc", pc_a, 32'h100);
        check("byp_imm", imm_a, 32'hFFFF8021);
        check("byp_regs", {rs_a, rt_a, rd_a}, {5'd5, 5'd0, 5'd16});
        check("byp_ctrl", {exc_a, mec_a, wbc_a}, {6'h2A, 2'd2, 2'd1});

        // storage read of r5 on both ports
        wb_en = 1'b0; src2_is_reg = 1'b1;
        instruction = mk(6'h00, 5'd5, 5'd5, 5'd1, 6'h20);
        tick();
        check("store_val1", val1_a, 32'hDEADBEEF);
        check("store_val2", val2_b, 32'hDEADBEEF);

        // r0 writes are ignored
        wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'h1234;
        instruction = mk(6'h00, 5'd0, 5'd0, 5'd1, 6'h20);
        tick();
        check("r0_bypass", val1_a, 32'd0);
        wb_en = 1'b0;
        tick();
        check("r0_store", val1_a, 32'd0);

        // invalid instruction clears the control bundles
        if_valid = 1'b0;
        tick();
        check("inv_valid", valid_a, 1'b0);
        check("inv_ctrl", {exc_a, mec_a, wbc_a}, 10'd0);

        // RAW with EXE producer, no load
        if_valid = 1'b1; src2_is_reg = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 5'd3;
        instruction = mk(6'h00, 5'd3, 5'd0, 5'd1, 6'h20);
        #1;
        check("raw_exe_freeze", {freeze_a, freeze_b}, 2'b10);
        tick();
        check("raw_bubble_a", {valid_a, exc_a, mec_a, wbc_a}, 11'd0);
        check("raw_b_loads", {valid_b, exc_b}, {1'b1, 6'h2A});
        check("raw_count", {cnt_a, cnt_b}, {4'd1, 16'd0});

        // rt match only counts when rt is read
        src2_is_reg = 1'b0;
        instruction = mk(6'h00, 5'd0, 5'd3, 5'd1, 6'h20);
        #1;
        check("rt_no_read", freeze_a, 1'b0);
        tick();
        check("rt_no_read_cnt", cnt_a, 4'd1);
        src2_is_reg = 1'b1;
        #1;
        check("rt_read", freeze_a, 1'b1);

        // MEM-stage producer
        exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 5'd3; src2_is_reg = 1'b0;
        instruction = mk(6'h00, 5'd3, 5'd0, 5'd1, 6'h20);
        #1;
        check("raw_mem_freeze", {freeze_a, freeze_b}, 2'b10);

        // load-use: one freeze cycle with forwarding
        mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        #1;
        check("lu_freeze", {freeze_a, freeze_b}, 2'b11);
        tick();
        check("lu_bubble_b", valid_b, 1'b0);
        check("lu_count", {cnt_a, cnt_b}, {4'd2, 16'd1});
        exe_wb_en = 1'b0; exe_mem_read = 1'b0; mem_wb_en = 1'b1;
        #1;
        check("lu_release", {freeze_a, freeze_b}, 2'b10);
        tick();
        check("lu_after", {valid_a, valid_b}, 2'b01);
        check("lu_count2", {cnt_a, cnt_b}, {4'd3, 16'd1});

        // flush beats hazard
        mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_mem_read = 1'b1; flush = 1'b1;
        #1;
        check("flush_freeze", {freeze_a, freeze_b}, 2'b00);
        tick();
        check("flush_valid", {valid_a, valid_b}, 2'b00);
        check("flush_count", {cnt_a, cnt_b}, {4'd3, 16'd1});

        // saturation of the 4-bit counter
        flush = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("sat_reach", {cnt_a, cnt_b}, {4'd15, 16'd13});
        for (int i = 0; i < 8; i++) tick();
        check("sat_hold", {cnt_a, cnt_b}, {4'd15, 16'd21});

        // reset during a stall clears everything, including the register file
        rst = 1'b1;
        tick();
        check("rst_mid_count", {cnt_a, cnt_b}, 64'd0);
        check("rst_mid_valid", {valid_a, valid_b}, 2'b00);
        rst = 1'b0; idle();
        if_valid = 1'b1; instruction = mk(6'h00, 5'd5, 5'd0, 5'd0, 6'h20);
        tick();
        check("rst_mid_r5", val1_a, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
